keypad_scanner: RTL

Active column driver and debouncer for the 4x4 matrix keypad. It walks a single low column across kypd_col and samples the active-low kypd_row lines. Each full sweep is resolved to a single key code, and the code is debounced over several consecutive sweeps. The block emits a one-cycle key_valid strobe per debounced press, plus a held level, for the recorder control logic. Its key map matches the existing keypad decoder exactly.

---
 rtl/keypad_if.sv | 19 +
 rtl/keypad_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_if.sv
// Signal bundle between the keypad scanner and the keypad matrix / recorder control logic.
// The master side is the scanner; the slave side is the keypad plus its consumer.
interface keypad_if;
    logic [3:0] kypd_row;
    logic [3:0] kypd_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  kypd_row,
        output kypd_col, key_code, key_valid, key_held
    );

    modport slave (
        output kypd_row,
        input  kypd_col, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad column scanner, with a sweep resolver and a press/release debouncer.
// It emits a one-cycle key_valid strobe per accepted press and holds key_held until the debounced release.
module keypad_scanner #(
    parameter int SCAN_TICKS      = 8,
    parameter int DEBOUNCE_SWEEPS = 3
) (
    input  logic     cclk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int         DW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] LAST_TICK = DW'(SCAN_TICKS - 1);
    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SWEEPS);

    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {SW_NONE, SW_SINGLE, SW_MULTI} sweep_t;

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          sample_tick, sweep_end;

    sweep_t     acc_kind, sweep_kind;
    logic [3:0] acc_code, sweep_code;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic [3:0] cand, cand_next;
    logic [3:0] code_q, code_next;
    logic       valid_q, valid_next, held_q, held_next;

    function automatic logic [3:0] decode_key(input logic [1:0] col, input logic [1:0] pos);
        logic [3:0] code;
        case ({col, pos})
            4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
            4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
            4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
            default: code = 4'hA + 4'({2'b00, pos});
        endcase
        return code;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.kypd_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (dwell == LAST_TICK) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign sample_tick = (dwell == LAST_TICK);
    assign sweep_end   = sample_tick && (col_idx == 2'd3);

    // Sweep result, including the sample that is being taken now.
    // NOTE: every always_comb output gets a default first, so the block cannot infer a latch.
    always_comb begin
        logic [1:0] pos;
        logic       one_low;
        sweep_kind = acc_kind;
        sweep_code = acc_code;
        pos        = 2'd0;
        one_low    = 1'b1;
        case (row_sync)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: one_low = 1'b0;
        endcase
        if (row_sync != 4'b1111) begin
            if (one_low && acc_kind == SW_NONE) begin
                sweep_kind = SW_SINGLE;
                sweep_code = decode_key(col_idx, pos);
            end else begin
                sweep_kind = SW_MULTI;
            end
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            acc_kind <= SW_NONE;
            acc_code <= 4'h0;
        end else if (sample_tick) begin
            acc_kind <= sweep_end ? SW_NONE : sweep_kind;
            acc_code <= sweep_end ? 4'h0 : sweep_code;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cand    <= 4'h0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cand    <= cand_next;
            code_q  <= code_next;
            valid_q <= valid_next;
            held_q  <= held_next;
        end
    end

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        code_next  = code_q;
        valid_next = 1'b0;
        held_next  = held_q;
        if (sweep_end) begin
            case (state)
                IDLE: if (sweep_kind == SW_SINGLE) begin
                    cand_next = sweep_code;
                    cnt_next  = 4'd1;
                    if (DB_TARGET == 4'd1) begin
                        code_next  = sweep_code;
                        valid_next = 1'b1;
                        held_next  = 1'b1;
                        state_next = PRESSED;
                    end else begin
                        state_next = CONFIRM;
                    end
                end
                CONFIRM: if (sweep_kind == SW_SINGLE && sweep_code == cand) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= DB_TARGET) begin
                        code_next  = cand;
                        valid_next = 1'b1;
                        held_next  = 1'b1;
                        state_next = PRESSED;
                    end
                end else if (sweep_kind == SW_SINGLE) begin
                    cand_next = sweep_code;
                    cnt_next  = 4'd1;
                end else begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end
                PRESSED: if (sweep_kind == SW_NONE) begin
                    if (DB_TARGET == 4'd1) begin
                        held_next  = 1'b0;
                        cnt_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = 4'd1;
                        state_next = RELEASE;
                    end
                end
                RELEASE: if (sweep_kind == SW_NONE) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= DB_TARGET) begin
                        held_next  = 1'b0;
                        cnt_next   = 4'd0;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next   = 4'd0;
                    state_next = PRESSED;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign kp.kypd_col  = ~(4'b0001 << col_idx);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule
